axil_reg_responder: RTL
=======================

Name: axil_reg_responder

Overview:
- AXI4-Lite responder (slave) terminating the bus initiator's five valid/ready channels.
- Holds a bank of NREGS 32-bit software registers and exposes their contents to fabric logic.
- Each input channel (AW, W, AR) has a one-entry holding stage, so the responder drives READY from a register and never combinationally from a downstream READY.
- Sits at the peripheral end of the AXI-Lite interconnect.

Parameters:
- C_AXI_ADDR_WIDTH, 4: byte address width. Register index is addr[C_AXI_ADDR_WIDTH-1:2].
- C_AXI_DATA_WIDTH, 32: data width. Fixed at 32; any other value is unsupported.
- NREGS, 4: number of registers. Must equal 2^(C_AXI_ADDR_WIDTH-2).
- OPT_LOWPOWER, 0: when 1, RDATA is forced to 0 whenever RVALID is low.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00 (OKAY).
- o_regs  out  32*NREGS  register contents; register k occupies bits [32k+31:32k].

Behaviour:
- Reset (synchronous, i_reset=1):
  - All registers clear to 0.
  - BVALID, RVALID and all holding-stage valid flags clear to 0.
  - AWREADY, WREADY and ARREADY read 1 in the first cycle after reset.
  - RDATA clears to 0.
  - Reset asserted mid-transaction discards any held AW/W/AR and any pending B/R; there is no response for them.
- Holding stages (AW, W, AR):
  - xREADY = !held_valid.
  - A beat is "available" if it is held, or if it is being handshaken this cycle (xVALID && xREADY).
  - An available beat that is not consumed in the same cycle is captured: held_valid <= 1, payload latched.
  - Consumption clears held_valid.
- Write fire:
  - Fires when AW is available, W is available, and (!BVALID || BREADY).
  - On fire, register[awidx] updates byte-wise: byte b is written only where WSTRB[b]=1.
  - BVALID is 1 in the next cycle.
  - AW and W may arrive in either order or in the same cycle. The first arrival waits in its holding stage.
  - With WSTRB=0 the write fires, no register changes, and a response is still issued.
- B channel:
  - BVALID stays high until BREADY is seen.
  - With BVALID && BREADY and a new fire in the same cycle, BVALID stays 1. This sustains one write per clock.
- Read fire:
  - Fires when AR is available and (!RVALID || RREADY).
  - On fire, RDATA <= register[aridx] and RVALID is 1 in the next cycle.
  - RDATA is stable while RVALID && !RREADY.
  - Sustains one read per clock while RREADY=1.
- Same-cycle read and write of the same index: the read returns the pre-write value. The next read returns the new value.
- Channel independence:
  - A stalled B never blocks reads.
  - A stalled R never blocks writes.
  - With both held stages full and B stalled, AWREADY=WREADY=0 until BREADY.
- o_regs reflects register state, updated in the cycle after the write fire.
- Protocol rule: VALID outputs never drop without a handshake.

Test Plan:
- Reset, then AW(addr 0x4) and W(0xDEADBEEF, strb 0xF) in the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=0; o_regs[63:32]=0xDEADBEEF.
- W(0x000000AA, strb 0x1) three cycles before AW(0x8) -> WREADY falls after capture; write fires on AW arrival; reg2=0x000000AA; B returned once.
- BREADY=0 while issuing two writes -> the second AW/W are held, AWREADY=WREADY=0, BVALID stays high. BREADY=1 -> two B handshakes in consecutive cycles; both writes applied in order.
- Back-to-back AR to 0x0, 0x4, 0x8, 0xC with RREADY=1 after writing 1, 2, 3, 4 -> RDATA 1, 2, 3, 4 on consecutive cycles, RVALID continuously high.
- RREADY=0 for 5 cycles with RVALID=1 -> RDATA held constant; a second AR is held, ARREADY=0.
- Same-cycle read and write of reg1 (old 0x11, new 0x22) -> RDATA=0x11; the following read gives 0x22. Assert i_reset with AW held and BVALID pending -> next cycle all VALIDs=0, all READYs=1, o_regs=0.

Source files
------------

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register-bank responder: NREGS 32-bit registers with registered READY
// on AW/W/AR (one-entry holding stage each) and one-transaction-per-clock B/R paths.
module axil_reg_responder #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int NREGS            = 4,
  parameter bit OPT_LOWPOWER     = 1'b0
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  output logic [1:0]                      S_AXI_BRESP,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic [C_AXI_DATA_WIDTH*NREGS-1:0] o_regs
);

  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = C_AXI_ADDR_WIDTH - 2;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] new_val,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_val;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic          aw_vld_p0, w_vld_p0, ar_vld_p0;
  logic [IW-1:0] aw_idx_p0, ar_idx_p0;
  logic [DW-1:0] w_data_p0;
  logic [SW-1:0] w_strb_p0;

  logic          bvalid_p1, rvalid_p1;
  logic [DW-1:0] rdata_p1;
  logic [DW-1:0] regs [NREGS];

  logic          aw_avail, w_avail, ar_avail;
  logic          wfire, rfire;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Holding-stage view: a beat is usable if held or arriving this cycle
  assign aw_avail = aw_vld_p0 || S_AXI_AWVALID;
  assign w_avail  = w_vld_p0  || S_AXI_WVALID;
  assign ar_avail = ar_vld_p0 || S_AXI_ARVALID;

  assign aw_idx = aw_vld_p0 ? aw_idx_p0 : S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
  assign ar_idx = ar_vld_p0 ? ar_idx_p0 : S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
  assign w_data = w_vld_p0  ? w_data_p0 : S_AXI_WDATA;
  assign w_strb = w_vld_p0  ? w_strb_p0 : S_AXI_WSTRB;

  assign wfire = aw_avail && w_avail && (!bvalid_p1 || S_AXI_BREADY);
  assign rfire = ar_avail && (!rvalid_p1 || S_AXI_RREADY);

  // Stage p0: one-entry holding registers, captured only when not consumed
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      aw_vld_p0 <= 1'b0;
      w_vld_p0  <= 1'b0;
      ar_vld_p0 <= 1'b0;
    end else begin
      aw_vld_p0 <= aw_avail && !wfire;
      w_vld_p0  <= w_avail && !wfire;
      ar_vld_p0 <= ar_avail && !rfire;
    end
  end

  always_ff @(posedge i_clk) begin
    if (S_AXI_AWVALID && !aw_vld_p0) aw_idx_p0 <= S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
    if (S_AXI_WVALID && !w_vld_p0) begin
      w_data_p0 <= S_AXI_WDATA;
      w_strb_p0 <= S_AXI_WSTRB;
    end
    if (S_AXI_ARVALID && !ar_vld_p0) ar_idx_p0 <= S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
  end

  // Stage p1: register update, B and R response registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (wfire) begin
      regs[aw_idx] <= apply_strb(regs[aw_idx], w_data, w_strb);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)             bvalid_p1 <= 1'b0;
    else if (wfire)          bvalid_p1 <= 1'b1;
    else if (S_AXI_BREADY)   bvalid_p1 <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else if (rfire) begin
      rvalid_p1 <= 1'b1;
      rdata_p1  <= regs[ar_idx];
    end else if (S_AXI_RREADY) begin
      rvalid_p1 <= 1'b0;
      if (OPT_LOWPOWER) rdata_p1 <= '0;
    end
  end

  assign S_AXI_AWREADY = !aw_vld_p0;
  assign S_AXI_WREADY  = !w_vld_p0;
  assign S_AXI_ARREADY = !ar_vld_p0;
  assign S_AXI_BVALID  = bvalid_p1;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_p1;
  assign S_AXI_RDATA   = rdata_p1;
  assign S_AXI_RRESP   = 2'b00;

  for (genvar k = 0; k < NREGS; k++) begin : g_out
    assign o_regs[k*DW +: DW] = regs[k];
  end

endmodule
